msg_sched_seq: RTL



---
 rtl/definitions.sv | 26 ++
 rtl/alu.sv | 24 ++
 rtl/msg_sched_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/definitions.sv
// rtl/definitions.sv - shared types and ALU encodings for the message-schedule sequencer
package definitions;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SIG1,
        ST_SIG0,
        ST_ADD0,
        ST_ADD7,
        ST_ADD16,
        ST_EMIT
    } msg_sched_state_e;

    localparam int kSchedWinSize = 16;

    typedef logic [3:0] alu_op_t;

    // kLA/kLB carry the SHA-256 small-sigma functions in this core's ALU
    localparam alu_op_t kNOP  = 4'h0;
    localparam alu_op_t kADDU = 4'h1;
    localparam alu_op_t kLA   = 4'h2;
    localparam alu_op_t kLB   = 4'h3;
    localparam alu_op_t kBEQ  = 4'h4;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - miner-core ALU: unsigned add, SHA-256 sigma0/sigma1, equality branch
module alu
    import definitions::*;
(
    input  alu_op_t     op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [31:0] result_o,
    output logic        branch_taken_o
);

    always_comb begin
        result_o = 32'd0;
        case (op_i)
            kADDU:   result_o = rs_i + rt_i;
            kLA:     result_o = {rs_i[6:0],  rs_i[31:7]}  ^ {rs_i[17:0], rs_i[31:18]} ^ (rs_i >> 3);
            kLB:     result_o = {rs_i[16:0], rs_i[31:17]} ^ {rs_i[18:0], rs_i[31:19]} ^ (rs_i >> 10);
            default: result_o = 32'd0;
        endcase
    end

    assign branch_taken_o = (op_i == kBEQ) && (rs_i == rt_i);

endmodule

// File: rtl/msg_sched_seq.sv
// rtl/msg_sched_seq.sv - SHA-256 message-schedule sequencer; MSG_SCHED_PASSTHRU_EN echoes W0..W15 during load
module msg_sched_seq
    import definitions::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        n_reset_i,
    input  logic        start_i,
    output logic        busy_o,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [31:0] w_o,
    output logic [5:0]  w_idx_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic        done_o
);

    localparam logic [5:0] kLastIdx  = 6'(ROUNDS - 1);
    localparam logic [3:0] kLoadLast = 4'(kSchedWinSize - 1);

    msg_sched_state_e state;
    logic [5:0]       t;
    logic [31:0]      acc;
    logic [31:0]      temp;
    logic [31:0]      wbuf [kSchedWinSize];

    logic             w_valid_q;
    logic [31:0]      w_q;
    logic [5:0]       w_idx_q;
    logic             busy_q;
    logic             done_q;

    alu_op_t          alu_op;
    logic [31:0]      alu_rs;
    logic [31:0]      alu_rt;
    logic [31:0]      alu_result;
    logic             unused_branch;

    logic [3:0]       widx;
    logic             in_load;
    logic             load_fire;
    logic             emit_fire;

    assign widx    = t[3:0];
    assign in_load = (state == ST_LOAD);

`ifdef MSG_SCHED_PASSTHRU_EN
    assign word_ready_o = in_load & w_ready_i;
    assign w_valid_o    = in_load ? word_valid_i : w_valid_q;
    assign w_o          = in_load ? word_i : w_q;
    assign w_idx_o      = in_load ? t : w_idx_q;
`else
    assign word_ready_o = in_load;
    assign w_valid_o    = w_valid_q;
    assign w_o          = w_q;
    assign w_idx_o      = w_idx_q;
`endif

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign load_fire = in_load & word_valid_i & word_ready_o;
    assign emit_fire = (state == ST_EMIT) & w_ready_i;

    // Window offsets are taken mod 16: t-2, t-15 (= t+1), t-7 (= t+9), t-16 (= t)
    always_comb begin
        alu_op = kNOP;
        alu_rs = 32'd0;
        alu_rt = 32'd0;
        case (state)
            ST_SIG1: begin
                alu_op = kLB;
                alu_rs = wbuf[widx - 4'd2];
            end
            ST_SIG0: begin
                alu_op = kLA;
                alu_rs = wbuf[widx + 4'd1];
            end
            ST_ADD0: begin
                alu_op = kADDU;
                alu_rs = acc;
                alu_rt = temp;
            end
            ST_ADD7: begin
                alu_op = kADDU;
                alu_rs = acc;
                alu_rt = wbuf[widx + 4'd9];
            end
            ST_ADD16: begin
                alu_op = kADDU;
                alu_rs = acc;
                alu_rt = wbuf[widx];
            end
            default: ;
        endcase
    end

    alu u_alu (
        .op_i           (alu_op),
        .rs_i           (alu_rs),
        .rt_i           (alu_rt),
        .result_o       (alu_result),
        .branch_taken_o (unused_branch)
    );

    // The window buffer carries no reset; every slot is written in LOAD before it is read
    always_ff @(posedge clk) begin
        if (load_fire) begin
            wbuf[widx] <= word_i;
        end else if (emit_fire) begin
            wbuf[widx] <= acc;
        end
    end

    always_ff @(posedge clk or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state     <= ST_IDLE;
            t         <= 6'd0;
            acc       <= 32'd0;
            temp      <= 32'd0;
            w_valid_q <= 1'b0;
            w_q       <= 32'd0;
            w_idx_q   <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_LOAD;
                        t      <= 6'd0;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        t <= t + 6'd1;
                        if (widx == kLoadLast) begin
                            state <= ST_SIG1;
                        end
                    end
                end
                ST_SIG1: begin
                    acc   <= alu_result;
                    state <= ST_SIG0;
                end
                ST_SIG0: begin
                    temp  <= alu_result;
                    state <= ST_ADD0;
                end
                ST_ADD0: begin
                    acc   <= alu_result;
                    state <= ST_ADD7;
                end
                ST_ADD7: begin
                    acc   <= alu_result;
                    state <= ST_ADD16;
                end
                ST_ADD16: begin
                    acc       <= alu_result;
                    state     <= ST_EMIT;
                    w_valid_q <= 1'b1;
                    w_q       <= alu_result;
                    w_idx_q   <= t;
                end
                ST_EMIT: begin
                    if (w_ready_i) begin
                        w_valid_q <= 1'b0;
                        w_q       <= 32'd0;
                        w_idx_q   <= 6'd0;
                        if (t == kLastIdx) begin
                            state  <= ST_IDLE;
                            t      <= 6'd0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            t     <= t + 6'd1;
                            state <= ST_SIG1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
